// File: rtl/avg_sequencer.sv
// AVG display-list sequencer: fetches 4-byte instruction words, acts on decoder
// controls, maintains PC and the JSR/RTS return stack, and hands vectors to the draw engine.
module avg_sequencer #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [15:0] START_ADDR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] inst,
    input  logic        dec_jmp,
    input  logic        dec_jsr,
    input  logic        dec_ret,
    input  logic        dec_halt,
    input  logic        dec_vector,
    input  logic [15:0] dec_jumpAddr,
    input  logic [2:0]  dec_pcOffset,
    output logic        exec_en,
    output logic        vec_start,
    input  logic        vec_done
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT_VEC, HALTED} state_e;

    state_e            state_q;
    logic [2:0]        k_q;
    logic [15:0]       pc_q;
    logic [SP_W-1:0]   sp_q;
    logic [15:0]       stack_q [2**IDX_W];
    logic [31:0]       inst_q;
    logic              busy_q, halted_q, err_q, rd_en_q, exec_en_q, vdone_q;
    logic [15:0]       addr_q;

    logic              dec_fault, dec_stop, dec_wait, dec_push, dec_pop;
    logic [15:0]       pc_seq, pc_tgt;

    assign pc_seq = pc_q + 16'(dec_pcOffset);

    // Resolve the decoded instruction by priority: halt > ret > jsr > jmp > vector > other.
    always_comb begin
        dec_fault = 1'b0;
        dec_stop  = 1'b0;
        dec_wait  = 1'b0;
        dec_push  = 1'b0;
        dec_pop   = 1'b0;
        pc_tgt    = pc_seq;
        if (dec_halt) begin
            dec_stop = 1'b1;
        end else if (dec_ret) begin
            if (sp_q == '0) begin
                dec_fault = 1'b1;
            end else begin
                dec_pop = 1'b1;
                pc_tgt  = stack_q[IDX_W'(sp_q - SP_W'(1))];
            end
        end else if (dec_jsr) begin
            if (sp_q == SP_W'(STACK_DEPTH)) begin
                dec_fault = 1'b1;
            end else begin
                dec_push = 1'b1;
                pc_tgt   = dec_jumpAddr;
            end
        end else if (dec_jmp) begin
            pc_tgt = dec_jumpAddr;
        end else if (dec_vector) begin
            dec_wait = 1'b1;
        end else if (dec_pcOffset == 3'd0) begin
            dec_fault = 1'b1;
        end
    end

    // Draw launch must coincide with the decode cycle, so it comes straight from the decoder.
    assign vec_start = (state_q == DECODE) && dec_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= 3'd0;
            pc_q      <= START_ADDR;
            sp_q      <= '0;
            inst_q    <= 32'd0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= 16'd0;
            exec_en_q <= 1'b0;
            vdone_q   <= 1'b0;
        end else begin
            exec_en_q <= 1'b0;
            vdone_q   <= 1'b0;
            case (state_q)
                IDLE, HALTED: begin
                    if (go) begin
                        pc_q     <= START_ADDR;
                        sp_q     <= '0;
                        err_q    <= 1'b0;
                        halted_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= FETCH;
                        k_q      <= 3'd0;
                        rd_en_q  <= 1'b1;
                        addr_q   <= START_ADDR;
                    end
                end
                FETCH: begin
                    k_q <= k_q + 3'd1;
                    case (k_q)
                        3'd1:    inst_q[31:24] <= mem_rdata;
                        3'd2:    inst_q[23:16] <= mem_rdata;
                        3'd3:    inst_q[15:8]  <= mem_rdata;
                        3'd4:    inst_q[7:0]   <= mem_rdata;
                        default: ;
                    endcase
                    rd_en_q <= (k_q < 3'd3);
                    if (k_q < 3'd3) begin
                        addr_q <= pc_q + 16'(k_q) + 16'd1;
                    end
                    if (k_q == 3'd4) begin
                        state_q   <= DECODE;
                        exec_en_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (dec_fault || dec_stop) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                        if (dec_fault) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        pc_q <= pc_tgt;
                        if (dec_push) begin
                            sp_q <= sp_q + SP_W'(1);
                        end else if (dec_pop) begin
                            sp_q <= sp_q - SP_W'(1);
                        end
                        if (dec_wait) begin
                            state_q <= WAIT_VEC;
                        end else begin
                            state_q <= FETCH;
                            k_q     <= 3'd0;
                            rd_en_q <= 1'b1;
                            addr_q  <= pc_tgt;
                        end
                    end
                end
                WAIT_VEC: begin
                    // Completion is registered, so the refetch starts one cycle after vec_done.
                    if (vdone_q) begin
                        state_q <= FETCH;
                        k_q     <= 3'd0;
                        rd_en_q <= 1'b1;
                        addr_q  <= pc_q;
                    end else begin
                        vdone_q <= vec_done;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Return stack storage; only written on a successful JSR.
    always_ff @(posedge clk) begin
        if (state_q == DECODE && dec_push && !dec_stop) begin
            stack_q[IDX_W'(sp_q)] <= pc_seq;
        end
    end

    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign inst      = inst_q;
    assign exec_en   = exec_en_q;

endmodule

// File: tb/tb_avg_sequencer.sv
// Directed bench for avg_sequencer with a byte ROM, a stub decoder and hand-derived expectations.
module tb_avg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        busy, halted, err, mem_rd_en, exec_en, vec_start;
    logic        vec_done = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] inst;
    logic        dec_jmp, dec_jsr, dec_ret, dec_halt, dec_vector;
    logic [15:0] dec_jumpAddr;
    logic [2:0]  dec_pcOffset;
    logic [2:0]  op;

    logic [7:0]  rom [65536];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          addr_log[$], addr_cyc[$], vs_cyc[$], ex_cyc[$];
    int          t;

    avg_sequencer #(.STACK_DEPTH(4), .START_ADDR(16'h0000)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .halted(halted), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .inst(inst),
        .dec_jmp(dec_jmp), .dec_jsr(dec_jsr), .dec_ret(dec_ret), .dec_halt(dec_halt),
        .dec_vector(dec_vector), .dec_jumpAddr(dec_jumpAddr), .dec_pcOffset(dec_pcOffset),
        .exec_en(exec_en), .vec_start(vec_start), .vec_done(vec_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= rom[mem_addr];

    always @(negedge clk) begin
        if (mem_rd_en) begin
            addr_log.push_back(int'(mem_addr));
            addr_cyc.push_back(cyc);
        end
        if (vec_start) vs_cyc.push_back(cyc);
        if (exec_en) ex_cyc.push_back(cyc);
    end

    // Stub decoder: op = inst[31:29]; 0 VCTR(4B) 1 HALT 2 SVEC 3 STAT(bit28 -> bad length) 5 JSR 6 RTS 7 JMP
    always_comb begin
        op           = inst[31:29];
        dec_halt     = (op == 3'd1);
        dec_ret      = (op == 3'd6);
        dec_jsr      = (op == 3'd5);
        dec_jmp      = (op == 3'd5) || (op == 3'd7);
        dec_vector   = (op == 3'd0) || (op == 3'd2);
        dec_jumpAddr = {inst[28], inst[28], inst[28:16], 1'b0};
        dec_pcOffset = (op == 3'd0) ? 3'd4 : ((op == 3'd3 && inst[28]) ? 3'd0 : 3'd2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_logs();
        addr_log.delete(); addr_cyc.delete(); vs_cyc.delete(); ex_cyc.delete();
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic do_go(output int tg);
        go = 1'b1;
        tg = cyc;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check_eq("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic wait_vec(input int budget);
        int n = 0;
        while (vs_cyc.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("vec_seen", 32'(vs_cyc.size()), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles, then idle with no go
        clear_rom();
        #1;
        repeat (3) begin
            tick();
            check_eq("rst_rd_en", 32'(mem_rd_en), 32'd0);
        end
        rst = 1'b0;
        clear_logs();
        repeat (3) tick();
        check_eq("idle_flags", 32'({busy, halted, err, vec_start, exec_en, mem_rd_en}), 32'd0);
        check_eq("idle_addr", 32'(mem_addr), 32'd0);
        check_eq("idle_inst", inst, 32'd0);
        check_eq("idle_reads", 32'(addr_log.size()), 32'd0);

        // VCTR then HALT, with a vec_done coincident with vec_start that must be ignored
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h33; rom[4] = 8'h20;
        do_go(t);
        check_eq("t2_busy", 32'(busy), 32'd1);
        tick_to(t + 6);
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        tick_to(t + 9);
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        wait_halt(40);
        check_eq("t2_nreads", 32'(addr_log.size()), 32'd8);
        check_eq("t2_addr3", 32'(addr_log[3]), 32'd3);
        check_eq("t2_addr7", 32'(addr_log[7]), 32'd7);
        check_eq("t2_cyc_a0", 32'(addr_cyc[0] - t), 32'd1);
        check_eq("t2_cyc_a3", 32'(addr_cyc[3] - t), 32'd4);
        check_eq("t2_cyc_a4", 32'(addr_cyc[4] - t), 32'd11);
        check_eq("t2_cyc_a7", 32'(addr_cyc[7] - t), 32'd14);
        check_eq("t2_nvec", 32'(vs_cyc.size()), 32'd1);
        check_eq("t2_cyc_vec", 32'(vs_cyc[0] - t), 32'd6);
        check_eq("t2_cyc_exec", 32'(ex_cyc[0] - t), 32'd6);
        check_eq("t2_err", 32'(err), 32'd0);
        check_eq("t2_pc", 32'(dut.pc_q), 32'h0004);
        check_eq("t2_inst", inst, 32'h2000_0000);
        check_eq("t2_busy_end", 32'(busy), 32'd0);

        // JSR 0x100 -> SVEC, RTS -> HALT at 2
        do_reset();
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'h80; rom[2] = 8'h20;
        rom[16'h100] = 8'h40; rom[16'h102] = 8'hC0;
        do_go(t);
        wait_vec(40);
        check_eq("t3_sp_in_sub", 32'(dut.sp_q), 32'd1);
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        wait_halt(60);
        check_eq("t3_nreads", 32'(addr_log.size()), 32'd16);
        check_eq("t3_fetch1", 32'(addr_log[4]), 32'h100);
        check_eq("t3_fetch2", 32'(addr_log[8]), 32'h102);
        check_eq("t3_fetch3", 32'(addr_log[12]), 32'h002);
        check_eq("t3_sp_end", 32'(dut.sp_q), 32'd0);
        check_eq("t3_err", 32'(err), 32'd0);

        // Five nested JSRs overflow a depth-4 stack
        do_reset();
        clear_rom();
        rom[16'h00] = 8'hA0; rom[16'h01] = 8'h08;
        rom[16'h10] = 8'hA0; rom[16'h11] = 8'h10;
        rom[16'h20] = 8'hA0; rom[16'h21] = 8'h18;
        rom[16'h30] = 8'hA0; rom[16'h31] = 8'h20;
        rom[16'h40] = 8'hA0; rom[16'h41] = 8'h28;
        do_go(t);
        wait_halt(200);
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_sp", 32'(dut.sp_q), 32'd4);
        check_eq("t4_nreads", 32'(addr_log.size()), 32'd20);
        check_eq("t4_last_addr", 32'(addr_log[19]), 32'h43);
        check_eq("t4_ndecode", 32'(ex_cyc.size()), 32'd5);
        check_eq("t4_ret_addr3", 32'(dut.stack_q[3]), 32'h32);
        clear_logs();
        do_go(t);
        check_eq("t4_err_cleared", 32'(err), 32'd0);
        check_eq("t4_halted_cleared", 32'(halted), 32'd0);
        wait_halt(200);

        // RTS with an empty stack
        do_reset();
        clear_rom();
        rom[0] = 8'hC0;
        do_go(t);
        wait_halt(40);
        check_eq("t5_err", 32'(err), 32'd1);
        repeat (5) tick();
        check_eq("t5_nreads", 32'(addr_log.size()), 32'd4);

        // JMP to 0xFFFE: fetch wraps to 0x0000
        do_reset();
        clear_rom();
        rom[0] = 8'hFF; rom[1] = 8'hFF; rom[16'hFFFE] = 8'h20;
        do_go(t);
        wait_halt(40);
        check_eq("t6_nreads", 32'(addr_log.size()), 32'd8);
        check_eq("t6_addr4", 32'(addr_log[4]), 32'hFFFE);
        check_eq("t6_addr5", 32'(addr_log[5]), 32'hFFFF);
        check_eq("t6_addr6", 32'(addr_log[6]), 32'h0000);
        check_eq("t6_addr7", 32'(addr_log[7]), 32'h0001);
        check_eq("t6_pc", 32'(dut.pc_q), 32'hFFFE);
        check_eq("t6_err", 32'(err), 32'd0);

        // Reset during fetch byte k=2 aborts at once
        clear_logs();
        do_go(t);
        tick_to(t + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check_eq("t6_rst_nreads", 32'(addr_log.size()), 32'd3);
        check_eq("t6_rst_halted", 32'(halted), 32'd0);

        // STAT with a good length, then one decoding to zero length
        do_reset();
        clear_rom();
        rom[0] = 8'h60; rom[2] = 8'h70;
        do_go(t);
        wait_halt(40);
        check_eq("t7_err", 32'(err), 32'd1);
        check_eq("t7_nreads", 32'(addr_log.size()), 32'd8);
        check_eq("t7_addr4", 32'(addr_log[4]), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
